// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for a 2-input gate: applies 00,10,01,11, waits a settle time,
// samples the gate output and scores it against an expected truth table.
//
// state  | meaning
// IDLE   | waiting for start; gate inputs held at 0, results from last run held
// SETTLE | a vector is applied; cnt counts settle cycles, sample on the last one
module gate_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 7,
  parameter logic [3:0]  EXPECT        = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       gate_in1,
  output logic       gate_in2,
  input  logic       gate_out1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result_vec,
  output logic [3:0] fail_mask
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;

  logic       sample;
  logic [1:0] idx_nxt;
  logic [3:0] result_upd;
  logic [3:0] mask_upd;

  // Results with the current vector folded in, so pass sees the final bit.
  always_comb begin
    sample          = (cnt == CNT_LAST);
    idx_nxt         = idx + 2'd1;
    result_upd      = result_vec;
    result_upd[idx] = gate_out1;
    mask_upd        = fail_mask;
    mask_upd[idx]   = gate_out1 ^ EXPECT[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= 8'd0;
      gate_in1   <= 1'b0;
      gate_in2   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      result_vec <= 4'd0;
      fail_mask  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            idx        <= 2'd0;
            cnt        <= 8'd0;
            gate_in1   <= 1'b0;
            gate_in2   <= 1'b0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            result_vec <= 4'd0;
            fail_mask  <= 4'd0;
          end
        end
        SETTLE: begin
          if (sample) begin
            result_vec <= result_upd;
            fail_mask  <= mask_upd;
            cnt        <= 8'd0;
            if (idx != 2'd3) begin
              // next vector goes out on the sample edge: no gap between vectors
              idx      <= idx_nxt;
              gate_in1 <= idx_nxt[0];
              gate_in2 <= idx_nxt[1];
            end else begin
              state    <= IDLE;
              idx      <= 2'd0;
              busy     <= 1'b0;
              gate_in1 <= 1'b0;
              gate_in2 <= 1'b0;
              done     <= 1'b1;
              pass     <= (mask_upd == 4'd0);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Directed bench for gate_selftest_ctrl: default instance (settle 7) and a settle-1
// instance, both driving a behavioural gate model; results checked via a scoreboard queue.
module tb_gate_selftest_ctrl;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] mask;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, start1;
  logic gate_in1, gate_in2, gate_out1, busy, done, pass;
  logic [3:0] result_vec, fail_mask;
  logic gate_in1_s1, gate_in2_s1, gate_out1_s1, busy_s1, done_s1, pass_s1;
  logic [3:0] result_vec_s1, fail_mask_s1;

  int   mode;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  // 0: OR, 1: stuck at 0, other: AND
  function automatic logic model(input int m, input logic a, input logic b);
    case (m)
      0:       return a | b;
      1:       return 1'b0;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t predict(input int m);
    exp_t       e;
    logic [1:0] vb;
    e.res = 4'd0;
    for (int v = 0; v < 4; v++) begin
      vb       = 2'(v);
      e.res[v] = model(m, vb[0], vb[1]);
    end
    e.mask = e.res ^ 4'b1110;
    e.pass = (e.mask == 4'd0);
    return e;
  endfunction

  assign gate_out1    = model(mode, gate_in1, gate_in2);
  assign gate_out1_s1 = model(mode, gate_in1_s1, gate_in2_s1);

  gate_selftest_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gate_in1(gate_in1), .gate_in2(gate_in2), .gate_out1(gate_out1),
    .busy(busy), .done(done), .pass(pass),
    .result_vec(result_vec), .fail_mask(fail_mask)
  );

  gate_selftest_ctrl #(.SETTLE_CYCLES(1), .EXPECT(4'b1110)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .gate_in1(gate_in1_s1), .gate_in2(gate_in2_s1), .gate_out1(gate_out1_s1),
    .busy(busy_s1), .done(done_s1), .pass(pass_s1),
    .result_vec(result_vec_s1), .fail_mask(fail_mask_s1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run on the settle-7 instance; poke adds start pulses mid-run.
  task automatic run7(input int m, input bit poke);
    int         k;
    int         busy_n;
    bit         vec_ok;
    logic [1:0] vb;
    exp_t       e;
    mode = m;
    sbq.push_back(predict(m));
    start = 1'b1;
    tick();
    start  = 1'b0;
    k      = 0;
    busy_n = 0;
    vec_ok = 1'b1;
    while (done !== 1'b1 && k < 200) begin
      if (busy === 1'b1) busy_n++;
      vb = 2'(k / 7);
      if ({gate_in2, gate_in1} !== vb) vec_ok = 1'b0;
      start = poke && (k == 3 || k == 20);
      tick();
      k++;
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'd28);
    chk("busy_cycles", 32'(busy_n), 32'd28);
    chk("vectors", {31'd0, vec_ok}, 32'd1);
    chk("idle_outputs", {29'd0, busy, gate_in1, gate_in2}, 32'd0);
    e = sbq.pop_front();
    chk("result_vec", {28'd0, result_vec}, {28'd0, e.res});
    chk("fail_mask", {28'd0, fail_mask}, {28'd0, e.mask});
    chk("pass", {31'd0, pass}, {31'd0, e.pass});
    tick();
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("hold_results", {23'd0, pass, result_vec, fail_mask}, {23'd0, e.pass, e.res, e.mask});
  endtask

  initial begin
    int   last_done;
    int   ndone;
    exp_t e;
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (2) tick();
    chk("reset_state", {19'd0, gate_in1, gate_in2, busy, done, pass, result_vec, fail_mask}, 32'd0);
    chk("reset_state_s1", {19'd0, gate_in1_s1, gate_in2_s1, busy_s1, done_s1, pass_s1,
                           result_vec_s1, fail_mask_s1}, 32'd0);

    start = 1'b1;
    tick();
    chk("reset_beats_start", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    run7(0, 1'b0);
    run7(1, 1'b0);
    run7(2, 1'b0);
    run7(0, 1'b1);

    // reset mid-run at E0+10
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun_reset", {19'd0, gate_in1, gate_in2, busy, done, pass, result_vec, fail_mask}, 32'd0);
    run7(0, 1'b0);

    // settle-1 instance with start held: back-to-back runs
    mode = 0;
    for (int r = 0; r < 6; r++) sbq.push_back(predict(0));
    start1    = 1'b1;
    tick();
    last_done = 0;
    ndone     = 0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) tick();
      if (done_s1 === 1'b1) begin
        ndone++;
        if (ndone == 1) chk("s1_first_latency", 32'(k), 32'd4);
        else chk("s1_interval", 32'(k - last_done), 32'd5);
        last_done = k;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("s1_results", {23'd0, pass_s1, result_vec_s1, fail_mask_s1},
              {23'd0, e.pass, e.res, e.mask});
        end
      end else if (last_done > 0 && k == last_done + 1) begin
        chk("s1_cleared", {23'd0, pass_s1, result_vec_s1, fail_mask_s1}, 32'd0);
        chk("s1_busy_again", {31'd0, busy_s1}, 32'd1);
      end
    end
    start1 = 1'b0;
    chk("s1_done_count", 32'(ndone), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_selftest_ctrl.md
Name: gate_selftest_ctrl

Overview:
Self-test sequencer for a 2-input logic gate such as the team's OR gate. On a start request it drives the four input combinations in the order (in1,in2) = 00, 10, 01, 11. It waits a programmable settle time after each vector, then samples the gate output and compares it against an expected truth table. It reports per-vector results, a failure mask and pass/done status, replacing hand-written delay-and-display testbenches with a reusable on-chip checker.

Parameters:
SETTLE_CYCLES, 7, clock cycles from applying a vector to sampling gate_out1; legal range 1..255
EXPECT, 4'b1110, expected gate output per vector index; bit i = expected output for vector i (OR default)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request a test run; accepted only in IDLE
gate_in1  output  1  drive to gate input 1; bit 0 of the vector index
gate_in2  output  1  drive to gate input 2; bit 1 of the vector index
gate_out1  input  1  gate output under test
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when a run completes
pass  output  1  1 if the last completed run had fail_mask==0; held until the next accepted start
result_vec  output  4  sampled gate_out1 per vector index
fail_mask  output  4  bit i set if result_vec[i] != EXPECT[i]

Behaviour:
- Reset: rst_n=0 at a rising edge forces state IDLE. All outputs go to 0: gate_in1, gate_in2, busy, done, pass, result_vec, fail_mask. Internal index and counter also clear. This applies mid-run; no partial results survive.
- States: IDLE, SETTLE.
- IDLE:
  - gate_in1=gate_in2=0, busy=0.
  - start=1 at edge E0 takes effect at that edge:
    - state→SETTLE, idx=0, cnt=0
    - gate_in1/gate_in2 driven with vector 0
    - busy=1
    - result_vec, fail_mask and pass cleared to 0
- SETTLE:
  - cnt increments each edge.
  - At the edge where cnt==SETTLE_CYCLES-1 (a sample edge):
    - result_vec[idx] <= gate_out1
    - fail_mask[idx] <= gate_out1 ^ EXPECT[idx]
    - cnt <= 0
  - If idx<3 at a sample edge: idx <= idx+1 and the next vector is driven on the same edge, so there are no idle cycles between vectors.
  - If idx==3 at a sample edge:
    - state→IDLE, busy=0, gate_in1/gate_in2 → 0
    - done=1 for exactly one cycle
    - pass <= (final fail_mask==0), including the bit just sampled
- Timing: each vector is held exactly SETTLE_CYCLES cycles. Sample edges fall at E0+k·SETTLE_CYCLES for k=1..4. done is high in the cycle after edge E0+4·SETTLE_CYCLES; total latency is 4·SETTLE_CYCLES cycles (28 at default).
- Vector mapping: idx → (gate_in1,gate_in2) = (idx[0], idx[1]).
- start while busy=1: ignored, with no effect on sequence or results.
- start high in the done-pulse cycle (state IDLE): accepted. This begins a new run at the next edge; done falls and results clear at that edge.
- start held high continuously: runs repeat back-to-back, each separated by the single IDLE/done cycle.
- Simultaneous rst_n=0 and start=1: reset wins.
- result_vec, fail_mask and pass hold their values after done until the next accepted start or reset. During a run, result_vec and fail_mask show partial results for vectors already sampled.
- Counter is 8 bits. SETTLE_CYCLES=1 is legal: every edge in SETTLE is a sample edge.

Test Plan:
- Ideal OR model on gate_out1, default parameters, start pulse at edge E0:
  - inputs step 00,10,01,11, 7 cycles each
  - done at cycle E0+28 with result_vec=4'b1110, fail_mask=4'b0000, pass=1
  - busy high for exactly 28 cycles
- gate_out1 tied 0: result_vec=4'b0000, fail_mask=4'b1110, pass=0, done after 28 cycles.
- AND model with EXPECT=4'b1110: result_vec=4'b1000, fail_mask=4'b0110, pass=0.
- start pulses at cycles E0+3 and E0+20 during a run: no restart, no timing change, done still at E0+28 only.
- rst_n=0 for one edge at E0+10: all outputs 0 on the next cycle. A subsequent start completes a full, correct 28-cycle run.
- SETTLE_CYCLES=1, start held high:
  - done every 5th cycle (4 sample cycles + 1 IDLE)
  - each run's results cleared at its acceptance edge
  - pass=1 with the ideal OR model
